// File: rtl/multicycle_ctrl_if.sv
// Bus between the multi-cycle sequencer and the rest of the RV32I datapath.
// The controller takes the master side; the datapath and memories take the slave side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             rw;
    logic [1:0]       whb;
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_write;
    logic             pc_we;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    modport master (
        input  instr, imem_ready, dmem_ready,
        output imem_req, ir_we, dmem_req, rw, whb, alu_ctrl, alu_src,
               mem_to_reg, reg_write, pc_we, illegal, timeout, instret, state
    );

    modport slave (
        output instr, imem_ready, dmem_ready,
        input  imem_req, ir_we, dmem_req, rw, whb, alu_ctrl, alu_src,
               mem_to_reg, reg_write, pc_we, illegal, timeout, instret, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the minimal RV32I core (R-type, I-arithmetic, load, store).
// Steps FETCH -> DECODE -> EXEC -> (MEM) -> WB, waits on memory handshakes with a
// bounded wait counter, traps illegal instructions and memory timeouts, counts retirements.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [8:0] LP_LIMIT = 9'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_aluCtrl;
    logic             r_aluSrc;
    logic             r_rw;
    logic [1:0]       r_whb;
    logic             r_memToReg;
    logic             r_isLoad;
    logic             r_isStore;
    logic             r_illegal;
    logic             r_timeout;
    logic [7:0]       r_waitCnt;
    logic [CNT_W-1:0] r_instret;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_legal;
    logic [3:0]       w_decAluCtrl;
    logic             w_decAluSrc;
    logic             w_decRw;
    logic [1:0]       w_decWhb;
    logic             w_decLoad;
    logic             w_decStore;
    logic [8:0]       w_waitNext;
    logic             w_imemReq;
    logic             w_irWe;
    logic             w_dmemReq;
    logic             w_pcWe;
    logic             w_regWrite;
    logic             w_setIllegal;
    logic             w_setTimeout;
    logic             w_ctrlValid;
    logic             w_unused;

    assign w_opcode   = bus.instr[6:0];
    assign w_funct3   = bus.instr[14:12];
    assign w_funct7   = bus.instr[31:25];
    assign w_unused   = ^{bus.instr[24:15], bus.instr[11:7]};
    assign w_waitNext = {1'b0, r_waitCnt} + 9'd1;

    // Decode the instruction word into the datapath control encodings; unknown words stay illegal.
    always_comb begin
        w_legal      = 1'b0;
        w_decAluCtrl = 4'b0000;
        w_decAluSrc  = 1'b0;
        w_decRw      = 1'b0;
        w_decWhb     = 2'b10;
        w_decLoad    = 1'b0;
        w_decStore   = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    case (w_funct3)
                        3'b000:  w_decAluCtrl = 4'b0000;
                        3'b001:  w_decAluCtrl = 4'b1010;
                        3'b100:  w_decAluCtrl = 4'b1000;
                        3'b101:  w_decAluCtrl = 4'b1001;
                        3'b110:  w_decAluCtrl = 4'b0100;
                        3'b111:  w_decAluCtrl = 4'b0010;
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_legal      = 1'b1;
                    w_decAluCtrl = 4'b0001;
                end
            end
            7'b0010011: begin
                w_decAluSrc = 1'b1;
                case (w_funct3)
                    3'b000: begin w_legal = 1'b1; w_decAluCtrl = 4'b0000; end
                    3'b100: begin w_legal = 1'b1; w_decAluCtrl = 4'b1000; end
                    3'b110: begin w_legal = 1'b1; w_decAluCtrl = 4'b0100; end
                    3'b111: begin w_legal = 1'b1; w_decAluCtrl = 4'b0010; end
                    3'b001: begin w_legal = (w_funct7 == 7'b0000000); w_decAluCtrl = 4'b1010; end
                    3'b101: begin w_legal = (w_funct7 == 7'b0000000); w_decAluCtrl = 4'b1001; end
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0000011, 7'b0100011: begin
                w_decAluSrc = 1'b1;
                w_decLoad   = (w_opcode == 7'b0000011);
                w_decStore  = (w_opcode == 7'b0100011);
                w_decRw     = w_decLoad;
                case (w_funct3)
                    3'b000:  begin w_legal = 1'b1; w_decWhb = 2'b00; end
                    3'b001:  begin w_legal = 1'b1; w_decWhb = 2'b01; end
                    3'b010:  begin w_legal = 1'b1; w_decWhb = 2'b10; end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state and strobe logic; memory waits give up once the wait counter would reach the limit.
    always_comb begin
        w_nextState  = r_state;
        w_imemReq    = 1'b0;
        w_irWe       = 1'b0;
        w_dmemReq    = 1'b0;
        w_pcWe       = 1'b0;
        w_regWrite   = 1'b0;
        w_setIllegal = 1'b0;
        w_setTimeout = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imemReq = 1'b1;
                if (bus.imem_ready) begin
                    w_irWe      = 1'b1;
                    w_nextState = S_DECODE;
                end else if (w_waitNext >= LP_LIMIT) begin
                    w_setTimeout = 1'b1;
                    w_nextState  = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_nextState = S_EXEC;
                end else begin
                    w_setIllegal = 1'b1;
                    w_nextState  = S_TRAP;
                end
            end
            S_EXEC: begin
                w_nextState = (r_isLoad || r_isStore) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_dmemReq = 1'b1;
                if (bus.dmem_ready) begin
                    if (r_isStore) begin
                        w_pcWe      = 1'b1;
                        w_nextState = S_FETCH;
                    end else begin
                        w_nextState = S_WB;
                    end
                end else if (w_waitNext >= LP_LIMIT) begin
                    w_setTimeout = 1'b1;
                    w_nextState  = S_TRAP;
                end
            end
            S_WB: begin
                w_regWrite  = 1'b1;
                w_pcWe      = 1'b1;
                w_nextState = S_FETCH;
            end
            S_TRAP:  w_nextState = S_TRAP;
            default: w_nextState = S_TRAP;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_nextState;
    end

    // Wait counter restarts on entry to FETCH or MEM and counts cycles without ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if ((w_nextState == S_FETCH || w_nextState == S_MEM) && w_nextState != r_state) begin
            r_waitCnt <= '0;
        end else if ((r_state == S_FETCH && !bus.imem_ready) || (r_state == S_MEM && !bus.dmem_ready)) begin
            r_waitCnt <= w_waitNext[7:0];
        end
    end

    // Capture decoded controls once in DECODE so they stay stable until the instruction retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluCtrl  <= 4'b0000;
            r_aluSrc   <= 1'b0;
            r_rw       <= 1'b0;
            r_whb      <= 2'b10;
            r_memToReg <= 1'b0;
            r_isLoad   <= 1'b0;
            r_isStore  <= 1'b0;
        end else if (r_state == S_DECODE && w_legal) begin
            r_aluCtrl  <= w_decAluCtrl;
            r_aluSrc   <= w_decAluSrc;
            r_rw       <= w_decRw;
            r_whb      <= w_decWhb;
            r_memToReg <= w_decLoad;
            r_isLoad   <= w_decLoad;
            r_isStore  <= w_decStore;
        end
    end

    // Sticky trap causes and the retired-instruction counter (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_setIllegal) r_illegal <= 1'b1;
            if (w_setTimeout) r_timeout <= 1'b1;
            if (w_pcWe)       r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Latched controls are only shown while an instruction is past DECODE; elsewhere they read as idle.
    assign w_ctrlValid    = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    assign bus.imem_req   = w_imemReq & rst_n;
    assign bus.ir_we      = w_irWe & rst_n;
    assign bus.dmem_req   = w_dmemReq;
    assign bus.pc_we      = w_pcWe;
    assign bus.reg_write  = w_regWrite;
    assign bus.rw         = w_ctrlValid ? r_rw       : 1'b0;
    assign bus.whb        = w_ctrlValid ? r_whb      : 2'b10;
    assign bus.alu_ctrl   = w_ctrlValid ? r_aluCtrl  : 4'b0000;
    assign bus.alu_src    = w_ctrlValid ? r_aluSrc   : 1'b0;
    assign bus.mem_to_reg = w_ctrlValid ? r_memToReg : 1'b0;
    assign bus.illegal    = r_illegal;
    assign bus.timeout    = r_timeout;
    assign bus.instret    = r_instret;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A table of supported instruction patterns
// predicts each instruction's controls; every cycle all outputs are compared at once.
module tb_multicycle_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [31:0] M_FULL = 32'hFE00707F;
    localparam logic [31:0] M_F3   = 32'h0000707F;

    typedef struct packed {
        logic             imemReq;
        logic             irWe;
        logic             dmemReq;
        logic             rw;
        logic [1:0]       whb;
        logic [3:0]       aluCtrl;
        logic             aluSrc;
        logic             memToReg;
        logic             regWrite;
        logic             pcWe;
        logic             illegal;
        logic             timeout;
        logic [2:0]       state;
        logic [CNT_W-1:0] instret;
    } outs_t;

    // kind: 0 = ALU op, 1 = load, 2 = store
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  alu;
        logic        src;
        logic [1:0]  kind;
        logic [1:0]  whb;
    } pat_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   errors;
    int   mCount;
    bit   mIllegal;
    bit   mTimeout;
    pat_t pats[$];

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns to a clock edge.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 10'b0, f3, 5'b0, op};
    endfunction

    function automatic void addPat(input logic [31:0] mask, input logic [6:0] f7, input logic [2:0] f3,
                                   input logic [6:0] op, input logic [3:0] alu, input logic src,
                                   input logic [1:0] kind, input logic [1:0] whb);
        pat_t p;
        p.mask  = mask;
        p.match = enc(f7, f3, op) & mask;
        p.alu   = alu;
        p.src   = src;
        p.kind  = kind;
        p.whb   = whb;
        pats.push_back(p);
    endfunction

    // The supported instruction set written as mask/match patterns.
    function automatic void buildTable();
        addPat(M_FULL, 7'h00, 3'd0, 7'b0110011, 4'b0000, 1'b0, 2'd0, 2'b10); // ADD
        addPat(M_FULL, 7'h20, 3'd0, 7'b0110011, 4'b0001, 1'b0, 2'd0, 2'b10); // SUB
        addPat(M_FULL, 7'h00, 3'd1, 7'b0110011, 4'b1010, 1'b0, 2'd0, 2'b10); // SLL
        addPat(M_FULL, 7'h00, 3'd4, 7'b0110011, 4'b1000, 1'b0, 2'd0, 2'b10); // XOR
        addPat(M_FULL, 7'h00, 3'd5, 7'b0110011, 4'b1001, 1'b0, 2'd0, 2'b10); // SRL
        addPat(M_FULL, 7'h00, 3'd6, 7'b0110011, 4'b0100, 1'b0, 2'd0, 2'b10); // OR
        addPat(M_FULL, 7'h00, 3'd7, 7'b0110011, 4'b0010, 1'b0, 2'd0, 2'b10); // AND
        addPat(M_F3,   7'h00, 3'd0, 7'b0010011, 4'b0000, 1'b1, 2'd0, 2'b10); // ADDI
        addPat(M_F3,   7'h00, 3'd4, 7'b0010011, 4'b1000, 1'b1, 2'd0, 2'b10); // XORI
        addPat(M_F3,   7'h00, 3'd6, 7'b0010011, 4'b0100, 1'b1, 2'd0, 2'b10); // ORI
        addPat(M_F3,   7'h00, 3'd7, 7'b0010011, 4'b0010, 1'b1, 2'd0, 2'b10); // ANDI
        addPat(M_FULL, 7'h00, 3'd1, 7'b0010011, 4'b1010, 1'b1, 2'd0, 2'b10); // SLLI
        addPat(M_FULL, 7'h00, 3'd5, 7'b0010011, 4'b1001, 1'b1, 2'd0, 2'b10); // SRLI
        addPat(M_F3,   7'h00, 3'd0, 7'b0000011, 4'b0000, 1'b1, 2'd1, 2'b00); // LB
        addPat(M_F3,   7'h00, 3'd1, 7'b0000011, 4'b0000, 1'b1, 2'd1, 2'b01); // LH
        addPat(M_F3,   7'h00, 3'd2, 7'b0000011, 4'b0000, 1'b1, 2'd1, 2'b10); // LW
        addPat(M_F3,   7'h00, 3'd0, 7'b0100011, 4'b0000, 1'b1, 2'd2, 2'b00); // SB
        addPat(M_F3,   7'h00, 3'd1, 7'b0100011, 4'b0000, 1'b1, 2'd2, 2'b01); // SH
        addPat(M_F3,   7'h00, 3'd2, 7'b0100011, 4'b0000, 1'b1, 2'd2, 2'b10); // SW
    endfunction

    function automatic void modelDecode(input logic [31:0] ins, output bit hit, output pat_t p);
        hit = 1'b0;
        p   = '0;
        foreach (pats[i]) begin
            if (!hit && ((ins & pats[i].mask) == pats[i].match)) begin
                hit = 1'b1;
                p   = pats[i];
            end
        end
    endfunction

    // Random instruction word: mostly near the supported opcodes, sometimes pure noise.
    function automatic logic [31:0] randInstr(input bit legalOnly);
        logic [31:0] w;
        bit          hit;
        pat_t        p;
        w = 32'h002081B3;
        for (int t = 0; t < 200; t++) begin
            w = $urandom();
            case ($urandom_range(0, 3))
                0:       w[6:0] = 7'b0110011;
                1:       w[6:0] = 7'b0010011;
                2:       w[6:0] = 7'b0000011;
                default: w[6:0] = 7'b0100011;
            endcase
            w[31:25] = ($urandom_range(0, 3) == 0) ? 7'b0100000 : 7'b0000000;
            if (!legalOnly && $urandom_range(0, 7) == 0) w[31:25] = 7'($urandom());
            if (!legalOnly && $urandom_range(0, 9) == 0) w = $urandom();
            modelDecode(w, hit, p);
            if (!legalOnly || hit) return w;
        end
        return 32'h002081B3;
    endfunction

    function automatic outs_t sampleDut();
        outs_t o;
        o.imemReq  = bus.imem_req;
        o.irWe     = bus.ir_we;
        o.dmemReq  = bus.dmem_req;
        o.rw       = bus.rw;
        o.whb      = bus.whb;
        o.aluCtrl  = bus.alu_ctrl;
        o.aluSrc   = bus.alu_src;
        o.memToReg = bus.mem_to_reg;
        o.regWrite = bus.reg_write;
        o.pcWe     = bus.pc_we;
        o.illegal  = bus.illegal;
        o.timeout  = bus.timeout;
        o.state    = bus.state;
        o.instret  = bus.instret;
        return o;
    endfunction

    function automatic outs_t baseExp(input logic [2:0] st);
        outs_t e;
        e         = '0;
        e.whb     = 2'b10;
        e.state   = st;
        e.illegal = mIllegal;
        e.timeout = mTimeout;
        e.instret = CNT_W'(mCount);
        return e;
    endfunction

    function automatic outs_t ctrlExp(input logic [2:0] st, input pat_t p);
        outs_t e;
        e          = baseExp(st);
        e.aluCtrl  = p.alu;
        e.aluSrc   = p.src;
        e.rw       = (p.kind == 2'd1);
        e.memToReg = (p.kind == 2'd1);
        e.whb      = p.whb;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, want);
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks at the falling edge.
    task automatic cycleCheck(input string tag, input outs_t e);
        @(negedge clk);
        checkOutput(tag, 32'(sampleDut()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        outs_t e;
        rst_n          = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        mCount         = 0;
        mIllegal       = 1'b0;
        mTimeout       = 1'b0;
        #2;
        e = baseExp(ST_FETCH);
        checkOutput("resetAsync", 32'(sampleDut()), 32'(e));
        cycleCheck("resetHold", e);
        rst_n = 1'b1;
    endtask

    // TRAP must ignore the handshake inputs and hold its flags.
    task automatic trapCheck(input string tag);
        for (int k = 0; k < 3; k++) begin
            bus.imem_ready = 1'($urandom());
            bus.dmem_ready = 1'($urandom());
            cycleCheck(tag, baseExp(ST_TRAP));
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    // One instruction from FETCH: fetchWait/memWait are the ready-low cycles before ready.
    task automatic applyStimulus(input logic [31:0] ins, input int fetchWait, input int memWait);
        bit    hit;
        pat_t  p;
        outs_t e;
        modelDecode(ins, hit, p);
        bus.instr = ins;
        for (int k = 0; k < MEM_TIMEOUT && k <= fetchWait; k++) begin
            bus.imem_ready = (k == fetchWait);
            e         = baseExp(ST_FETCH);
            e.imemReq = 1'b1;
            e.irWe    = bus.imem_ready;
            cycleCheck("fetch", e);
        end
        bus.imem_ready = 1'b0;
        if (fetchWait >= MEM_TIMEOUT) begin
            mTimeout = 1'b1;
            trapCheck("fetchTimeoutTrap");
            return;
        end
        cycleCheck("decode", baseExp(ST_DECODE));
        if (!hit) begin
            mIllegal = 1'b1;
            trapCheck("illegalTrap");
            return;
        end
        cycleCheck("exec", ctrlExp(ST_EXEC, p));
        if (p.kind != 2'd0) begin
            for (int k = 0; k < MEM_TIMEOUT && k <= memWait; k++) begin
                bus.dmem_ready = (k == memWait);
                e         = ctrlExp(ST_MEM, p);
                e.dmemReq = 1'b1;
                e.pcWe    = (p.kind == 2'd2) && bus.dmem_ready;
                cycleCheck("mem", e);
            end
            bus.dmem_ready = 1'b0;
            if (memWait >= MEM_TIMEOUT) begin
                mTimeout = 1'b1;
                trapCheck("memTimeoutTrap");
                return;
            end
            if (p.kind == 2'd2) begin
                mCount++;
                return;
            end
        end
        e          = ctrlExp(ST_WB, p);
        e.regWrite = 1'b1;
        e.pcWe     = 1'b1;
        cycleCheck("writeback", e);
        mCount++;
    endtask

    // Directed cases first, then random traffic, then a reset in the middle of a load.
    initial begin
        outs_t e;
        bit    hit;
        pat_t  p;
        tests          = 0;
        errors         = 0;
        mCount         = 0;
        mIllegal       = 1'b0;
        mTimeout       = 1'b0;
        rst_n          = 1'b0;
        bus.instr      = 32'h0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        buildTable();
        @(posedge clk);
        #1;
        resetDut();

        applyStimulus(32'h002081B3, 0, 0);
        applyStimulus(32'h402081B3, 0, 0);
        applyStimulus(32'h00409283, 0, 3);
        applyStimulus(32'h00208023, 1, 2);
        for (int i = 0; i < 14; i++)
            applyStimulus(randInstr(1'b1), $urandom_range(0, MEM_TIMEOUT - 1), $urandom_range(0, MEM_TIMEOUT - 1));
        checkOutput("instretWrap", 32'(bus.instret), 32'd2);

        applyStimulus(32'h0000006F, 0, 0);
        resetDut();
        applyStimulus(32'h40209193, 0, 0);
        resetDut();
        applyStimulus(32'h002081B3, MEM_TIMEOUT, 0);
        resetDut();
        applyStimulus(32'h002081B3, MEM_TIMEOUT - 1, 0);
        applyStimulus(32'h0000A103, 0, MEM_TIMEOUT);
        resetDut();
        applyStimulus(32'h00208023, 0, MEM_TIMEOUT - 1);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(randInstr(1'b0), $urandom_range(0, MEM_TIMEOUT), $urandom_range(0, MEM_TIMEOUT));
            if (mIllegal || mTimeout) resetDut();
        end

        applyStimulus(32'h002081B3, 0, 0);
        bus.instr      = 32'h0000A103;
        modelDecode(bus.instr, hit, p);
        bus.imem_ready = 1'b1;
        e              = baseExp(ST_FETCH);
        e.imemReq      = 1'b1;
        e.irWe         = 1'b1;
        cycleCheck("arFetch", e);
        bus.imem_ready = 1'b0;
        cycleCheck("arDecode", baseExp(ST_DECODE));
        cycleCheck("arExec", ctrlExp(ST_EXEC, p));
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        checkOutput("arMemReq", 32'(bus.dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arReqDrop", 32'(bus.dmem_req), 32'd0);
        checkOutput("arStateDrop", 32'(bus.state), 32'(ST_FETCH));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mCount   = 0;
        mIllegal = 1'b0;
        mTimeout = 1'b0;
        e         = baseExp(ST_FETCH);
        e.imemReq = 1'b1;
        cycleCheck("arAfterRelease", e);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the minimal RV32I core. It drives fetch, decode, execute, memory and writeback one step at a time over the shared ALU, register file and memory ports. It supports the R-type, I-arithmetic, load and store subset, and produces the same control encodings the rest of the datapath already uses. It handles memory wait states, traps illegal instructions and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before trap (range 2..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents; stable from DECODE to end of instruction
imem_ready  in  1  instruction memory has data / ack this cycle
dmem_ready  in  1  data memory access complete this cycle
imem_req  out  1  instruction fetch request
ir_we  out  1  load instruction register
dmem_req  out  1  data memory request
rw  out  1  1 = read (load), 0 = write (store)
whb  out  2  access size: 10 word, 01 half, 00 byte
alu_ctrl  out  4  ADD 0000, SUB 0001, AND 0010, OR 0100, XOR 1000, SRL 1001, SLL 1010
alu_src  out  1  1 = immediate operand B
mem_to_reg  out  1  1 = writeback from memory
reg_write  out  1  register file write enable
pc_we  out  1  PC += 4 strobe
illegal  out  1  sticky: unsupported instruction trapped
timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
instret  out  CNT_W  retired-instruction count
state  out  3  debug state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; every output 0 except whb=10.
  - Latched control registers and wait counter cleared; instret=0.
  - Reset mid-instruction abandons the instruction immediately; requests drop without waiting for a clock edge.
- FETCH:
  - imem_req=1.
  - Cycle with imem_ready=1: ir_we=1 in that same cycle, next state DECODE.
- DECODE:
  - Decode opcode/funct3/funct7 and register all controls, which are held stable through EXEC/MEM/WB.
  - Supported instructions:
    - R (0110011), funct7=0000000: ADD, SLL, XOR, SRL, OR, AND. funct7=0100000 with funct3=000: SUB.
    - I1 (0010011): ADDI, XORI, ORI, ANDI for any funct7; SLLI/SRLI only with funct7=0000000.
    - Load (0000011): LW/LH/LB. Store (0100011): SW/SH/SB. Both use alu_ctrl=0000, alu_src=1.
  - Anything else, including any other opcode or funct combination, goes to TRAP.
- EXEC:
  - alu_ctrl/alu_src valid.
  - R/I1 go to WB; load/store go to MEM.
- MEM:
  - dmem_req=1 with rw/whb held.
  - On dmem_ready: a load goes to WB; a store sets pc_we=1, increments instret, and goes to FETCH.
- WB:
  - reg_write=1 for exactly one cycle; mem_to_reg=1 only for loads.
  - pc_we=1 and instret increments in the same cycle; next state FETCH.
- Latency with zero wait: ALU op 4 cycles (F, D, E, WB); load 5; store 4. Each wait cycle adds 1.
- Wait counter:
  - Clears on entering FETCH or MEM; increments each cycle ready is low.
  - If the counter reaches MEM_TIMEOUT with ready still low: set timeout=1 and go to TRAP.
  - Ready arriving in the same cycle the counter hits the limit counts as success.
- TRAP:
  - All requests and strobes 0; illegal/timeout held; absorbing until reset.
- Outputs are never X: in FETCH/DECODE/TRAP, alu_ctrl=0000, alu_src=0, rw=0, mem_to_reg=0.
- reg_write, pc_we and ir_we are never high together except pc_we+reg_write in WB.
- instret wraps modulo 2^CNT_W.

Test Plan:
- ADD: instr=0x002081B3, imem_ready=1 -> ir_we at cycle 0; EXEC alu_ctrl=0000, alu_src=0; cycle 3 reg_write=1, pc_we=1, mem_to_reg=0; instret=1.
- SUB then LH: 0x402081B3 -> alu_ctrl=0001. Then 0x00409283 with dmem_ready delayed 3 cycles -> dmem_req=1, rw=1, whb=01 for 4 cycles; WB with mem_to_reg=1; total 8 cycles; instret=2.
- SB: 0x00208023 -> MEM state with rw=0, whb=00, dmem_req=1; reg_write stays 0; pc_we pulse on dmem_ready; back to FETCH.
- Illegal: 0x0000006F (JAL) and SLLI with funct7=0100000 -> state=7, illegal=1, no reg_write/pc_we; remains in TRAP until rst_n low.
- Timeout, MEM_TIMEOUT=4: imem_ready held 0 -> timeout=1 and TRAP after 4 wait cycles. Repeat with ready asserted on the 4th cycle -> normal DECODE.
- Async reset asserted in MEM with dmem_req=1 -> dmem_req falls before the next clk edge; after release, state=FETCH and instret=0.
